fetch_unit: RTL and testbench

//  PC register and instruction-fetch front end of the RV32 core, the consumer of the branch unit's next_pc.

---
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RV32 instruction-fetch front end: PC register, single-outstanding imem requests, small instruction FIFO.
// Optional FETCH_MISALIGN_TRAP_EN halts fetch on a misaligned redirect target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        misalign
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DRAIN
`ifdef FETCH_MISALIGN_TRAP_EN
    , S_HALT
`endif
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic               req_valid_q, req_valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             fifo_q [FIFO_DEPTH];
  logic               push, pop, flush, pending, accept;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic               halt_pend_q, halt_pend_d;
  logic               misalign_q, misalign_d;
`endif

  assign accept = req_valid_q & imem_req_ready;

  // Next-state: FSM, PC, FIFO bookkeeping; redirect overrides everything
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    pop      = (count_q != '0) & inst_ready;
    flush    = 1'b0;
    pending  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    halt_pend_d = halt_pend_q;
    misalign_d  = misalign_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (accept) begin
          pc_d     = pc_q + 32'd4;
          req_pc_d = req_addr_q;
          state_d  = S_WAIT;
          pending  = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          push    = 1'b1;
          state_d = S_FETCH;
        end else begin
          pending = 1'b1;
        end
      end
      S_DRAIN: begin
        if (imem_resp_valid) state_d = S_FETCH;
        else                 pending = 1'b1;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_HALT: begin
        pending = halt_pend_q & ~imem_resp_valid;
        if (imem_resp_valid) halt_pend_d = 1'b0;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    if (redirect_en) begin
      pc_d  = redirect_pc;
      push  = 1'b0;
      pop   = 1'b0;
      flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d     = S_HALT;
        halt_pend_d = pending;
        misalign_d  = 1'b1;
      end else begin
        state_d     = pending ? S_DRAIN : S_FETCH;
        halt_pend_d = 1'b0;
        misalign_d  = 1'b0;
      end
`else
      state_d = pending ? S_DRAIN : S_FETCH;
`endif
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // No outstanding request exists in FETCH, so free slots are simply DEPTH - count
    req_valid_d = (state_d == S_FETCH) && (count_d < CNT_W'(FIFO_DEPTH));
    req_addr_d  = {pc_d[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_addr_q  <= '0;
      req_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_pend_q <= 1'b0;
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_addr_q  <= req_addr_d;
      req_valid_q <= req_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if (push) fifo_q[wr_ptr_q] <= '{pc: req_pc_q, data: imem_resp_data};
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_pend_q <= halt_pend_d;
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign inst_valid     = (count_q != '0);
  assign inst_data      = fifo_q[rd_ptr_q].data;
  assign inst_pc        = fifo_q[rd_ptr_q].pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign       = misalign_q;
`else
  assign misalign       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: main instance at RESET_PC=0, second instance checks RESET_PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req_ready;
  logic        inst_ready;
  int          lat;

  logic        req_valid, inst_valid, misalign, resp_valid;
  logic [31:0] req_addr, inst_data, inst_pc, resp_data;
  logic        req2_valid, inst2_valid, misalign2, resp2_valid;
  logic [31:0] req2_addr, inst2_data, inst2_pc, resp2_data;

  int          checks = 0;
  int          errors = 0;
  int          pend;
  logic [31:0] paddr;

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .misalign(misalign)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req_valid(req2_valid), .imem_req_addr(req2_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(resp2_valid), .imem_resp_data(resp2_data),
    .inst_valid(inst2_valid), .inst_data(inst2_data), .inst_pc(inst2_pc),
    .inst_ready(inst_ready), .misalign(misalign2)
  );

  // Memory for the main instance: response lat+1 cycles after acceptance
  always @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      pend       <= 0;
    end else begin
      resp_valid <= 1'b0;
      if (pend != 0) begin
        pend <= pend - 1;
        if (pend == 1) begin
          resp_valid <= 1'b1;
          resp_data  <= f(paddr);
        end
      end else if (req_valid && imem_req_ready) begin
        paddr <= req_addr;
        if (lat == 0) begin
          resp_valid <= 1'b1;
          resp_data  <= f(req_addr);
        end else begin
          pend <= lat;
        end
      end
    end
  end

  // Memory for the second instance: fixed one-cycle response
  always @(posedge clk) begin
    resp2_valid <= !rst && req2_valid && imem_req_ready;
    resp2_data  <= f(req2_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst         = 1'b1;
    redirect_en = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    lat            = 0;

    // Reset state and sequential fetch; dut2 wraps past 0xFFFFFFFC
    reset_dut();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst2_req_valid", 32'(req2_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("seq_req_valid_%0d", i), 32'(req_valid), 32'd1);
      chk($sformatf("seq_req_addr_%0d", i), req_addr, 32'(4 * i));
      chk($sformatf("seq2_req_addr_%0d", i), req2_addr, 32'hFFFF_FFF8 + 32'(4 * i));
      if (i > 0) begin
        chk($sformatf("seq_inst_valid_%0d", i), 32'(inst_valid), 32'd1);
        chk($sformatf("seq_inst_pc_%0d", i), inst_pc, 32'(4 * (i - 1)));
        chk($sformatf("seq_inst_data_%0d", i), inst_data, f(32'(4 * (i - 1))));
        chk($sformatf("seq2_inst_pc_%0d", i), inst2_pc, 32'hFFFF_FFF8 + 32'(4 * (i - 1)));
      end
      step();
      chk($sformatf("seq_req_idle_%0d", i), 32'(req_valid), 32'd0);
    end

    // Backpressure: FIFO fills with pc 0,4 and fetch stalls until decode drains
    inst_ready = 1'b0;
    reset_dut();
    repeat (5) step();
    chk("full_req_valid", 32'(req_valid), 32'd0);
    chk("full_inst_pc", inst_pc, 32'h0);
    repeat (3) step();
    chk("stall_req_valid", 32'(req_valid), 32'd0);
    chk("stall_inst_pc", inst_pc, 32'h0);
    chk("stall_req_addr", req_addr, 32'h8);
    inst_ready = 1'b1;
    step();
    chk("pop1_inst_pc", inst_pc, 32'h4);
    chk("pop1_req_valid", 32'(req_valid), 32'd1);
    chk("pop1_req_addr", req_addr, 32'h8);
    step();
    chk("pop2_inst_valid", 32'(inst_valid), 32'd0);
    step();
    chk("resume_inst_pc", inst_pc, 32'h8);

    // Redirect during WAIT with a slow response: the late word is drained
    lat = 2;
    reset_dut();
    step();
    chk("rw_req_addr0", req_addr, 32'h0);
    step();
    redirect_en = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_en = 1'b0;
    chk("rw_drain_req_valid", 32'(req_valid), 32'd0);
    chk("rw_drain_req_addr", req_addr, 32'h100);
    step();
    chk("rw_drain2_req_valid", 32'(req_valid), 32'd0);
    step();
    chk("rw_dropped_inst_valid", 32'(inst_valid), 32'd0);
    chk("rw_refetch_valid", 32'(req_valid), 32'd1);
    chk("rw_refetch_addr", req_addr, 32'h100);
    repeat (4) step();
    chk("rw_inst_valid", 32'(inst_valid), 32'd1);
    chk("rw_inst_pc", inst_pc, 32'h100);
    chk("rw_inst_data", inst_data, f(32'h100));

    // Redirect coinciding with resp_valid flushes buffered word and drops the response
    lat        = 0;
    inst_ready = 1'b0;
    reset_dut();
    repeat (4) step();
    redirect_en = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_en = 1'b0;
    chk("rr_flush_inst_valid", 32'(inst_valid), 32'd0);
    chk("rr_req_valid", 32'(req_valid), 32'd1);
    chk("rr_req_addr", req_addr, 32'h200);
    inst_ready = 1'b1;
    step();
    step();
    chk("rr_inst_pc", inst_pc, 32'h200);

    // Redirect on the cycle a request is accepted, with a misaligned target masked
    redirect_en = 1'b1;
    redirect_pc = 32'h302;
    step();
    redirect_en = 1'b0;
    chk("ra_drain_req_valid", 32'(req_valid), 32'd0);
    chk("ra_req_addr", req_addr, 32'h300);
    step();
    chk("ra_refetch_valid", 32'(req_valid), 32'd1);
    chk("ra_refetch_addr", req_addr, 32'h300);
    chk("ra_inst_valid", 32'(inst_valid), 32'd0);
    step();
    step();
    chk("ra_inst_pc", inst_pc, 32'h300);
`ifndef FETCH_MISALIGN_TRAP_EN
    chk("ra_misalign_tied", 32'(misalign), 32'd0);
`else
    // Misaligned redirect halts fetch until an aligned redirect
    reset_dut();
    step();
    redirect_en = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect_en = 1'b0;
    chk("halt_misalign", 32'(misalign), 32'd1);
    chk("halt_req_valid", 32'(req_valid), 32'd0);
    repeat (4) step();
    chk("halt_hold_req_valid", 32'(req_valid), 32'd0);
    chk("halt_hold_inst_valid", 32'(inst_valid), 32'd0);
    redirect_en = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_en = 1'b0;
    chk("unhalt_misalign", 32'(misalign), 32'd0);
    chk("unhalt_req_valid", 32'(req_valid), 32'd1);
    chk("unhalt_req_addr", req_addr, 32'h200);
    step();
    step();
    chk("unhalt_inst_pc", inst_pc, 32'h200);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
